// File: rtl/ctrl_pkg.sv
// Shared definitions for the vector control unit: FSM state codes, opcode
// class and ALU operation constants.
package ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_MEM  = 2'd2;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_MEM  = 2'b01;
  localparam logic [1:0] CLS_BR   = 2'b10;
  localparam logic [1:0] CLS_VMEM = 2'b11;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADD1 = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  // Both memory classes (scalar and vector) have the low class bit set.
  function automatic logic is_mem_class(input logic [1:0] cls);
    return cls[0];
  endfunction

endpackage

// File: rtl/cond_flag_unit.sv
// Condition flag register written by compares, and branch-taken generation
// from the opcode cond bit.
module cond_flag_unit (
  input  logic clk,
  input  logic reset,
  input  logic cmp_we,
  input  logic alu_flag,
  input  logic cond,
  input  logic br_valid,
  output logic pc_src
);

  logic flag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else if (cmp_we) begin
      flag_q <= alu_flag;
    end
  end

  // Unconditional branches always take; conditional ones follow the last compare.
  assign pc_src = br_valid & (~cond | flag_q);

endmodule

// File: rtl/vec_control_unit.sv
// Multi-cycle control unit: fetch handshake, ALU/branch execute and scalar or
// LANES-element vector memory sequencing. Optional macro VEC_CTRL_MEM_TIMEOUT_EN
// adds a per-beat mem_ack timeout that reports mem_err and aborts to IDLE.
//
// state | meaning
// IDLE  | ready for a new opcode
// EXEC  | single-cycle ALU or branch execute
// MEM   | memory beat(s) in flight, waiting for mem_ack
module vec_control_unit
  import ctrl_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   instr_valid,
  input  logic [OP_W-1:0]                        opcode,
  output logic                                   instr_ready,
  input  logic                                   alu_flag,
  input  logic                                   mem_ack,
  output logic                                   mem_req,
  output logic                                   mem_write,
  output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_idx,
  output logic                                   reg_write,
  output logic                                   add1_sel,
  output logic [1:0]                             alu_control,
  output logic [1:0]                             source,
  output logic                                   pc_src,
  output logic                                   busy,
  output logic                                   illegal,
  output logic                                   mem_err
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t          state_q, state_d;
  logic [5:0]      op_q;
  logic [LW-1:0]   lane_q;
  logic [1:0]      cls, aop;
  logic            in_exec, in_mem, accept, beat_done, last_lane, timeout;
  logic            cmp_we, br_valid;

  assign cls     = op_q[4:3];
  assign aop     = op_q[2:1];
  assign in_exec = (state_q == ST_EXEC);
  assign in_mem  = (state_q == ST_MEM);
  assign accept  = instr_valid & instr_ready;

  assign beat_done = in_mem & mem_ack & ~timeout;
  assign last_lane = (cls != CLS_VMEM) || (lane_q == LW'(LANES - 1));

  generate
    if (OP_W > 6) begin : g_opcode_hi
      logic unused_opcode_hi;
      assign unused_opcode_hi = ^opcode[OP_W-1:6];
    end
  endgenerate

`ifdef VEC_CTRL_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_q;

  // Down-counter reloaded outside MEM and on every ack, so each beat gets a fresh budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q <= '0;
    end else if (!in_mem || mem_ack) begin
      wait_q <= TW'(TIMEOUT_CYC - 1);
    end else if (wait_q != '0) begin
      wait_q <= wait_q - 1'b1;
    end
  end

  assign timeout = in_mem && (wait_q == '0);
  assign mem_err = timeout;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mem_class(opcode[4:3]) ? ST_MEM : ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      ST_MEM:  if (timeout || (beat_done && last_lane)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= opcode[5:0];
      if (timeout || (beat_done && last_lane)) begin
        lane_q <= '0;
      end else if (beat_done) begin
        lane_q <= lane_q + 1'b1;
      end
    end
  end

  assign cmp_we   = in_exec && (cls == CLS_ALU) && (aop == OP_CMP);
  assign br_valid = in_exec && (cls == CLS_BR) && !op_q[0];

  cond_flag_unit u_cond_flag (
    .clk      (clk),
    .reset    (reset),
    .cmp_we   (cmp_we),
    .alu_flag (alu_flag),
    .cond     (op_q[5]),
    .br_valid (br_valid),
    .pc_src   (pc_src)
  );

  // instr_ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    instr_ready = (state_q == ST_IDLE) & reset;
    busy        = (state_q != ST_IDLE);
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    add1_sel    = 1'b0;
    alu_control = 2'b00;
    source      = 2'b00;
    illegal     = 1'b0;
    lane_idx    = lane_q;
    if (in_exec) begin
      source = cls;
      if (cls == CLS_ALU) begin
        alu_control = aop;
        add1_sel    = (aop == OP_ADD1);
        reg_write   = (aop != OP_CMP);
      end
      if (cls == CLS_BR) illegal = op_q[0];
    end
    if (in_mem) begin
      source    = cls;
      mem_req   = ~timeout;
      mem_write = op_q[0] & ~timeout;
      reg_write = beat_done & ~op_q[0];
    end
  end

endmodule

// File: tb/tb_vec_control_unit.sv
// Self-checking bench for vec_control_unit: directed scenarios followed by
// random opcode/handshake sequences against a per-instruction reference model.
module tb_vec_control_unit;

  localparam int LANES = 4;
  localparam int LW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [5:0]    opcode;
  logic          instr_ready;
  logic          alu_flag;
  logic          mem_ack;
  logic          mem_req;
  logic          mem_write;
  logic [LW-1:0] lane_idx;
  logic          reg_write;
  logic          add1_sel;
  logic [1:0]    alu_control;
  logic [1:0]    source;
  logic          pc_src;
  logic          busy;
  logic          illegal;
  logic          mem_err;

  int checks = 0;
  int errors = 0;
  logic m_flag = 1'b0;

  vec_control_unit #(.LANES(LANES), .OP_W(6), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(instr_ready), .alu_flag(alu_flag), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_write(mem_write), .lane_idx(lane_idx),
    .reg_write(reg_write), .add1_sel(add1_sel), .alu_control(alu_control),
    .source(source), .pc_src(pc_src), .busy(busy), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge while the unit should be idle.
  task automatic idle_chk();
    chk("idle_ready", instr_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    chk("idle_reg_write", reg_write, 0);
    chk("idle_pc_src", pc_src, 0);
    chk("idle_illegal", illegal, 0);
    chk("idle_lane", 8'(lane_idx), 0);
    chk("idle_mem_err", mem_err, 0);
  endtask

  // Present op in IDLE; returns one step later with the op accepted.
  task automatic issue(input logic [5:0] op);
    instr_valid = 1'b1;
    opcode      = op;
    #4;
    idle_chk();
    step();
    instr_valid = 1'($urandom_range(0, 1));
    opcode      = 6'($urandom);
  endtask

  task automatic exec_op(input logic [5:0] op, input logic flag_in);
    logic [1:0] cls;
    logic [1:0] aop;
    logic       is_alu, is_br, exp_pc;
    cls    = op[4:3];
    aop    = op[2:1];
    is_alu = (cls == 2'b00);
    is_br  = (cls == 2'b10);
    alu_flag = flag_in;
    issue(op);
    mem_ack = 1'($urandom_range(0, 1));
    exp_pc  = is_br && !op[0] && (!op[5] || m_flag);
    #4;
    chk("exec_busy", busy, 1);
    chk("exec_ready", instr_ready, 0);
    chk("exec_source", source, cls);
    chk("exec_alu_control", alu_control, is_alu ? aop : 2'b00);
    chk("exec_add1_sel", add1_sel, is_alu && aop == 2'b01);
    chk("exec_reg_write", reg_write, is_alu && aop != 2'b10);
    chk("exec_pc_src", pc_src, exp_pc);
    chk("exec_illegal", illegal, is_br && op[0]);
    chk("exec_mem_req", mem_req, 0);
    if (is_alu && aop == 2'b10) m_flag = flag_in;
    step();
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
  endtask

  // delay < 0 picks a random 0..3 cycle ack delay per beat.
  task automatic mem_op(input logic [5:0] op, input int delay);
    int nb;
    int d;
    nb = (op[4:3] == 2'b11) ? LANES : 1;
    issue(op);
    for (int b = 0; b < nb; b++) begin
      d = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
      for (int k = 0; k < d; k++) begin
        mem_ack = 1'b0;
        #4;
        chk("mem_wait_req", mem_req, 1);
        chk("mem_wait_write", mem_write, op[0]);
        chk("mem_wait_reg_write", reg_write, 0);
        chk("mem_wait_lane", 8'(lane_idx), 8'(b));
        chk("mem_wait_busy", busy, 1);
        chk("mem_wait_ready", instr_ready, 0);
        chk("mem_wait_source", source, op[4:3]);
        chk("mem_wait_err", mem_err, 0);
        step();
        instr_valid = 1'($urandom_range(0, 1));
        opcode      = 6'($urandom);
      end
      mem_ack = 1'b1;
      #4;
      chk("mem_ack_req", mem_req, 1);
      chk("mem_ack_write", mem_write, op[0]);
      chk("mem_ack_reg_write", reg_write, !op[0]);
      chk("mem_ack_lane", 8'(lane_idx), 8'(b));
      step();
      mem_ack = 1'b0;
    end
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; instr_valid = 1'b0; opcode = '0; alu_flag = 1'b0; mem_ack = 1'b0;
    #3;
    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_lane", 8'(lane_idx), 0);
    #9 reset = 1'b1;
    step();

    exec_op(6'b000010, 1'b0);
    exec_op(6'b000100, 1'b1);
    exec_op(6'b110000, 1'b0);
    exec_op(6'b000100, 1'b0);
    exec_op(6'b110000, 1'b1);
    exec_op(6'b010000, 1'b0);
    mem_op(6'b011001, 2);
    mem_op(6'b001000, 0);
    exec_op(6'b010001, 1'b1);
    exec_op(6'b000110, 1'b0);

    // Abort a vector store at lane 2 with an asynchronous reset.
    issue(6'b011001);
    instr_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    #1;
    chk("pre_abort_lane", 8'(lane_idx), 2);
    reset = 1'b0;
    m_flag = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_write", mem_write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_lane", 8'(lane_idx), 0);
    chk("abort_ready", instr_ready, 0);
    chk("abort_source", source, 0);
    #5 reset = 1'b1;
    step();
    #4;
    idle_chk();
    step();

`ifdef VEC_CTRL_MEM_TIMEOUT_EN
    issue(6'b001000);
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    for (int k = 1; k < 16; k++) begin
      #4;
      chk("to_wait_req", mem_req, 1);
      chk("to_wait_err", mem_err, 0);
      step();
    end
    #4;
    chk("to_err", mem_err, 1);
    chk("to_req_drop", mem_req, 0);
    chk("to_reg_write", reg_write, 0);
    chk("to_busy", busy, 1);
    step();
    #4;
    idle_chk();
    step();
`else
    mem_op(6'b001000, 20);
`endif

    exec_op(6'b000100, 1'b1);
    exec_op(6'b110000, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      op = 6'($urandom);
      if (op[3]) mem_op(op, -1);
      else exec_op(op, 1'($urandom_range(0, 1)));
    end

    #4;
    idle_chk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
